// File: rtl/param_instruction_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : param_instruction_queue                                          |
// | Purpose  : In-order instruction queue for the Tomasulo front end. Decoded   |
// |            instructions are buffered in a circular FIFO. The head entry is  |
// |            issued to the execution unit it names while that unit reports a  |
// |            free reservation station. The issue is confirmed one cycle later |
// |            (issue_error=0 pops the entry; issue_error=1 keeps it for retry).|
// |            A head entry naming a nonexistent unit is discarded with drop.   |
// | Ports    : clock, reset_n (async, active-low)                               |
// |            enq_valid/enq_ready + enq_operation/unit/dest/A/B  (from decode) |
// |            unit_available[NUM_UNITS], issue_error            (from RS array)|
// |            operation, execution_unit, Dest_address, A_address, B_address,   |
// |            issue, drop, count                                (to RS array)  |
// |            flush (only when IQ_FLUSH_EN is defined)                         |
// | Options  : IQ_FLUSH_EN - adds a synchronous flush input                     |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module param_instruction_queue #(
   parameter int DEPTH     = 8,
   parameter int NUM_UNITS = 3,
   parameter int OP_W      = 6,
   parameter int UNIT_W    = 3,
   parameter int ADDR_W    = 5
) (
   input  logic                     clock,
   input  logic                     reset_n,
`ifdef IQ_FLUSH_EN
   input  logic                     flush,
`endif
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [OP_W-1:0]          enq_operation,
   input  logic [UNIT_W-1:0]        enq_unit,
   input  logic [ADDR_W-1:0]        enq_dest,
   input  logic [ADDR_W-1:0]        enq_A,
   input  logic [ADDR_W-1:0]        enq_B,
   input  logic [NUM_UNITS-1:0]     unit_available,
   input  logic                     issue_error,
   output logic [OP_W-1:0]          operation,
   output logic [UNIT_W-1:0]        execution_unit,
   output logic [ADDR_W-1:0]        Dest_address,
   output logic [ADDR_W-1:0]        A_address,
   output logic [ADDR_W-1:0]        B_address,
   output logic                     issue,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [UNIT_W-1:0] unit;
      logic [ADDR_W-1:0] dest;
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
   } entry_t;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_CONFIRM = 1'b1
   } state_t;

   entry_t             entry_mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   state_t             state_q, state_d;
   entry_t             out_q, out_d;
   logic               issue_q, issue_d;
   logic               drop_q, drop_d;

   entry_t             head;
   logic               empty, full, push, pop;
   logic               head_unit_ok, head_avail;

   assign head      = entry_mem[rd_ptr_q];
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));
   // Only occupancy gates acceptance; a pop in the same cycle does not
   // free a slot early.
   assign enq_ready = !full;

   // Unit index range check and availability lookup without indexing
   // unit_available out of range.
   always_comb begin
      head_unit_ok = (int'(head.unit) < NUM_UNITS);
      head_avail   = 1'b0;
      for (int u = 0; u < NUM_UNITS; u++) begin
         if (int'(head.unit) == u) head_avail = unit_available[u];
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      out_d    = out_q;
      issue_d  = 1'b0;
      drop_d   = 1'b0;
      push     = enq_valid && !full;
      pop      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               if (!head_unit_ok) begin
                  pop    = 1'b1;
                  drop_d = 1'b1;
               end else if (head_avail) begin
                  out_d   = head;
                  issue_d = 1'b1;
                  state_d = ST_CONFIRM;
               end
            end
         end
         ST_CONFIRM: begin
            // A rejected issue leaves the head in place for a later retry.
            state_d = ST_IDLE;
            if (!issue_error) pop = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef IQ_FLUSH_EN
      if (flush) begin
         push    = 1'b0;
         pop     = 1'b0;
         state_d = ST_IDLE;
         issue_d = 1'b0;
         drop_d  = 1'b0;
         out_d   = out_q;
      end
`endif

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

`ifdef IQ_FLUSH_EN
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
`endif
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_IDLE;
         out_q    <= '0;
         issue_q  <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         out_q    <= out_d;
         issue_q  <= issue_d;
         drop_q   <= drop_d;
      end
   end

   // Storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clock) begin
      if (push) begin
         entry_mem[wr_ptr_q] <= '{op: enq_operation, unit: enq_unit, dest: enq_dest,
                                  a: enq_A, b: enq_B};
      end
   end

   assign operation      = out_q.op;
   assign execution_unit = out_q.unit;
   assign Dest_address   = out_q.dest;
   assign A_address      = out_q.a;
   assign B_address      = out_q.b;
   assign issue          = issue_q;
   assign drop           = drop_q;
   assign count          = count_q;

endmodule
`default_nettype wire
